// File: rtl/note_tone_player.sv
// Note player: accepts (code, beats) commands and renders each as a square wave
// timed purely in prescaler ticks, followed by a silent articulation gap.
module note_tone_player #(
    parameter int NOTE_W      = 4,
    parameter int DUR_W       = 4,
    parameter int HP_W        = 12,
    parameter int BEAT_TICKS  = 250000,
    parameter int GAP_TICKS   = 20000,
    parameter int HP_OVERRIDE = 0  // nonzero replaces every tonal half-period
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              stop,
    input  logic              note_valid,
    input  logic [NOTE_W-1:0] note_code,
    input  logic [DUR_W-1:0]  note_dur,
    output logic              note_ready,
    output logic              busy,
    output logic              audio_out,
    output logic              note_done,
    output logic [NOTE_W-1:0] cur_note
);

    localparam int TICK_W = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [TICK_W-1:0] BEAT_LAST = TICK_W'(BEAT_TICKS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

    state_t            state, state_nxt;
    logic [NOTE_W-1:0] code_q;
    logic [DUR_W-1:0]  dur_q;
    logic [HP_W-1:0]   hp_q;
    logic [HP_W-1:0]   tone_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [DUR_W-1:0]  beat_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              audio_q;
    logic              accept;
    logic              beat_wrap;
    logic              gap_last;

    // Half periods in ticks at a 1 MHz tick; zero marks a rest code.
    function automatic logic [HP_W-1:0] hp_lookup(input logic [NOTE_W-1:0] code);
        logic [HP_W-1:0] hp;
        case (int'(code))
            1:       hp = HP_W'(3822);
            2:       hp = HP_W'(3608);
            3:       hp = HP_W'(3405);
            4:       hp = HP_W'(3214);
            5:       hp = HP_W'(3034);
            6:       hp = HP_W'(2863);
            7:       hp = HP_W'(2703);
            8:       hp = HP_W'(2551);
            9:       hp = HP_W'(2408);
            10:      hp = HP_W'(2273);
            11:      hp = HP_W'(2145);
            12:      hp = HP_W'(2025);
            default: hp = '0;
        endcase
        if (HP_OVERRIDE != 0 && hp != '0) hp = HP_W'(HP_OVERRIDE);
        return hp;
    endfunction

    assign note_ready = (state == S_IDLE) & ~stop;
    assign accept     = note_valid & note_ready;
    assign busy       = (state != S_IDLE);
    assign cur_note   = busy ? code_q : '0;
    assign audio_out  = audio_q;
    assign beat_wrap  = tick & (tick_cnt == BEAT_LAST) & (beat_cnt + DUR_W'(1) == dur_q);
    assign gap_last   = tick & (gap_cnt == GAP_LAST);
    assign note_done  = (state == S_GAP) & gap_last & ~stop;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the next state is defaulted first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (accept) state_nxt = S_LOAD;
                S_LOAD:  state_nxt = (dur_q == '0) ? S_GAP : S_PLAY;
                S_PLAY:  if (beat_wrap) state_nxt = S_GAP;
                S_GAP:   if (gap_last) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q   <= '0;
            dur_q    <= '0;
            hp_q     <= '0;
            tone_cnt <= '0;
            tick_cnt <= '0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            audio_q  <= 1'b0;
        end else if (stop) begin
            code_q   <= '0;
            dur_q    <= '0;
            hp_q     <= '0;
            tone_cnt <= '0;
            tick_cnt <= '0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            audio_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        code_q <= note_code;
                        dur_q  <= note_dur;
                    end
                end
                S_LOAD: begin
                    hp_q     <= hp_lookup(code_q);
                    tone_cnt <= '0;
                    tick_cnt <= '0;
                    beat_cnt <= '0;
                    gap_cnt  <= '0;
                    audio_q  <= 1'b0;
                end
                S_PLAY: begin
                    if (beat_wrap) begin
                        // Last beat ends: silence wins over any coincident toggle.
                        audio_q  <= 1'b0;
                        tone_cnt <= '0;
                        tick_cnt <= '0;
                        beat_cnt <= '0;
                    end else if (tick) begin
                        if (hp_q != '0) begin
                            if (tone_cnt == hp_q - HP_W'(1)) begin
                                audio_q  <= ~audio_q;
                                tone_cnt <= '0;
                            end else begin
                                tone_cnt <= tone_cnt + HP_W'(1);
                            end
                        end
                        if (tick_cnt == BEAT_LAST) begin
                            tick_cnt <= '0;
                            beat_cnt <= beat_cnt + DUR_W'(1);
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    audio_q <= 1'b0;
                    if (tick) gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + GAP_W'(1);
                end
                default: audio_q <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_note_tone_player.sv
// Bench for note_tone_player: two instances (table half-periods and hp=3 override)
// share stimulus and are compared every clock against a tick-count model.
module tb_note_tone_player;

    localparam int BT = 4;
    localparam int GT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       stop = 1'b0;
    logic       note_valid = 1'b0;
    logic [3:0] note_code = '0;
    logic [3:0] note_dur = '0;
    logic [1:0] ready_w, busy_w, audio_w, done_w;
    logic [3:0] cur_w [2];

    always #5 clk = ~clk;

    note_tone_player #(.BEAT_TICKS(BT), .GAP_TICKS(GT)) u_tab (
        .clk(clk), .rst_n(rst_n), .tick(tick), .stop(stop),
        .note_valid(note_valid), .note_code(note_code), .note_dur(note_dur),
        .note_ready(ready_w[0]), .busy(busy_w[0]), .audio_out(audio_w[0]),
        .note_done(done_w[0]), .cur_note(cur_w[0])
    );

    note_tone_player #(.BEAT_TICKS(BT), .GAP_TICKS(GT), .HP_OVERRIDE(3)) u_ovr (
        .clk(clk), .rst_n(rst_n), .tick(tick), .stop(stop),
        .note_valid(note_valid), .note_code(note_code), .note_dur(note_dur),
        .note_ready(ready_w[1]), .busy(busy_w[1]), .audio_out(audio_w[1]),
        .note_done(done_w[1]), .cur_note(cur_w[1])
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a note is LOAD, then a run of ticks numbered e = 0 .. dur*BT+GT-1.
    // Ticks below dur*BT are tone, the rest are gap; audio is bit 0 of e/hp.
    int hp_tab [13] = '{0, 3822, 3608, 3405, 3214, 3034, 2863, 2703, 2551, 2408, 2273, 2145, 2025};
    bit m_busy [2];
    bit m_load [2];
    int m_e    [2];
    int m_code [2];
    int m_dur  [2];

    function automatic int m_hp(input int i, input int code);
        if (code < 1 || code > 12) return 0;
        return (i == 1) ? 3 : hp_tab[code];
    endfunction

    function automatic int exp_audio(input int i);
        int hp;
        hp = m_hp(i, m_code[i]);
        if (!m_busy[i] || m_load[i] || hp == 0 || m_e[i] >= m_dur[i] * BT) return 0;
        return (m_e[i] / hp) % 2;
    endfunction

    function automatic int exp_done(input int i);
        return int'(m_busy[i] && !m_load[i] && tick && !stop && m_e[i] == m_dur[i] * BT + GT - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n || stop) begin
                m_busy[i] = 1'b0;
                m_load[i] = 1'b0;
                m_e[i]    = 0;
            end else if (!m_busy[i]) begin
                if (note_valid) begin
                    m_busy[i] = 1'b1;
                    m_load[i] = 1'b1;
                    m_code[i] = int'(note_code);
                    m_dur[i]  = int'(note_dur);
                    m_e[i]    = 0;
                end
            end else if (m_load[i]) begin
                m_load[i] = 1'b0;
            end else if (tick) begin
                if (m_e[i] + 1 == m_dur[i] * BT + GT) m_busy[i] = 1'b0;
                else m_e[i]++;
            end
        end
    end

    // Running per-instance tallies used for the hand-computed per-note checks.
    int rises [2] = '{0, 0};
    int highs [2] = '{0, 0};
    int busys [2] = '{0, 0};
    int dones [2] = '{0, 0};
    bit prev_audio [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("busy[%0d]", i), int'(busy_w[i]), int'(m_busy[i]));
            check($sformatf("ready[%0d]", i), int'(ready_w[i]), int'(!m_busy[i] && !stop));
            check($sformatf("cur_note[%0d]", i), int'(cur_w[i]), m_busy[i] ? m_code[i] : 0);
            check($sformatf("audio[%0d]", i), int'(audio_w[i]), exp_audio(i));
            check($sformatf("note_done[%0d]", i), int'(done_w[i]), exp_done(i));
            if (audio_w[i] && !prev_audio[i]) rises[i]++;
            prev_audio[i] = audio_w[i];
            if (audio_w[i]) highs[i]++;
            if (busy_w[i]) busys[i]++;
            if (done_w[i]) dones[i]++;
        end
    end

    int tick_div = 1;
    int tick_ph  = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (tick_div <= 1) begin
                tick = 1'b1;
            end else begin
                tick    = (tick_ph == 0);
                tick_ph = (tick_ph + 1) % tick_div;
            end
        end
    endtask

    // Plays one note to completion; negative expectations are skipped.
    task automatic play(input string tag, input int code, input int dur, input int budget,
                        input int exp_busy, input int exp_rise0, input int exp_rise1,
                        input int exp_high1);
        int r0, r1, h1, b0, d0, d1;
        bit got;
        r0 = rises[0]; r1 = rises[1]; h1 = highs[1];
        b0 = busys[0]; d0 = dones[0]; d1 = dones[1];
        got = 1'b0;
        note_valid = 1'b1;
        note_code  = 4'(code);
        note_dur   = 4'(dur);
        step(1);
        note_valid = 1'b0;
        check({tag, " ready_after_accept"}, int'(ready_w[0]), 0);
        check({tag, " cur_note_latched"}, int'(cur_w[1]), code);
        for (int k = 0; k < budget; k++) begin
            step(1);
            if (dones[0] != d0) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, " done_within_budget"}, int'(got), 1);
        step(1);
        check({tag, " done_pulses_tab"}, dones[0] - d0, 1);
        check({tag, " done_pulses_ovr"}, dones[1] - d1, 1);
        check({tag, " ready_after_done"}, int'(ready_w[0]), 1);
        check({tag, " rises_tab"}, rises[0] - r0, exp_rise0);
        check({tag, " rises_ovr"}, rises[1] - r1, exp_rise1);
        if (exp_high1 >= 0) check({tag, " high_clks_ovr"}, highs[1] - h1, exp_high1);
        if (exp_busy >= 0) check({tag, " busy_clks"}, busys[0] - b0, exp_busy);
    endtask

    initial begin
        int d0, d1;
        step(3);
        check("reset ready", int'(ready_w[0]), 1);
        check("reset busy", int'(busy_w[1]), 0);
        check("reset audio", int'(audio_w[1]), 0);
        check("reset cur_note", int'(cur_w[0]), 0);
        rst_n = 1'b1;
        step(2);

        // A3 with 4-tick beats: table hp 2273 never completes; hp=3 rises at tick 3.
        play("t1_a3", 10, 1, 50, 7, 0, 1, 1);
        // hp=3, two beats: high on ticks 3..5, low 6..7, then 2 gap ticks.
        play("t2_two_beats", 5, 2, 50, 11, 0, 1, 3);
        // Tick every 6th clk: the single high half-period lasts exactly 6 clks.
        tick_div = 6;
        tick_ph  = 0;
        play("t3_slow_tick", 3, 1, 300, -1, 0, 1, 6);
        tick_div = 1;
        step(2);
        play("t4_rest0", 0, 3, 100, 15, 0, 0, 0);
        play("t4_rest14", 14, 3, 100, 15, 0, 0, 0);
        play("t5_dur0", 7, 0, 50, 3, 0, 0, 0);

        // Abort mid-PLAY, then stop together with a valid command in IDLE.
        d0 = dones[0]; d1 = dones[1];
        note_valid = 1'b1; note_code = 4'd1; note_dur = 4'd3;
        step(1);
        note_valid = 1'b0;
        step(5);
        stop = 1'b1;
        check("t6 ready_under_stop", int'(ready_w[1]), 0);
        step(1);
        check("t6 busy_after_stop", int'(busy_w[0]), 0);
        check("t6 audio_after_stop", int'(audio_w[1]), 0);
        check("t6 cur_after_stop", int'(cur_w[1]), 0);
        note_valid = 1'b1; note_code = 4'd4; note_dur = 4'd2;
        step(1);
        check("t6 stop_blocks_accept", int'(busy_w[1]), 0);
        stop = 1'b0; note_valid = 1'b0;
        step(2);
        check("t6 no_done_tab", dones[0] - d0, 0);
        check("t6 no_done_ovr", dones[1] - d1, 0);

        // Async reset in the middle of the gap.
        note_valid = 1'b1; note_code = 4'd2; note_dur = 4'd1;
        step(1);
        note_valid = 1'b0;
        step(6);
        check("t6 in_gap_busy", int'(busy_w[1]), 1);
        rst_n = 1'b0;
        #1;
        check("t6 rst busy", int'(busy_w[1]), 0);
        check("t6 rst ready", int'(ready_w[1]), 1);
        check("t6 rst cur_note", int'(cur_w[1]), 0);
        check("t6 rst audio", int'(audio_w[1]), 0);
        check("t6 rst note_done", int'(done_w[1]), 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("t6 no_done_after_rst", dones[1] - d1, 0);

        play("t7_recover", 12, 1, 50, 7, 0, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
